// File: rtl/sr_pkg.sv
// Shared encodings and limits for the m_sr_bank set/reset flag bank.
package sr_pkg;

  // Conflict resolution when set and reset are requested together.
  localparam int unsigned SR_SET_WINS = 0;
  localparam int unsigned SR_RST_WINS = 1;
  localparam int unsigned SR_HOLD     = 2;
  localparam int unsigned SR_TOGGLE   = 3;
  localparam int unsigned SR_COMPAT   = 4;

  // Request triggering.
  localparam int unsigned SR_LEVEL = 0;
  localparam int unsigned SR_EDGE  = 1;

  localparam int unsigned SR_MAX_WIDTH = 32;
  localparam int unsigned SR_MAX_SYNC  = 3;

endpackage

// File: rtl/m_sr_sync.sv
// Generic WIDTH-bit, STAGES-deep synchroniser; every flop resets to 1 (request inactive).
module m_sr_sync #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  if (STAGES == 0) begin : g_bypass
    logic w_unused;
    assign w_unused = ^{i_clk, i_rst};
    assign o_q      = i_d;
  end else begin : g_flops
    logic [WIDTH-1:0] r_stage [STAGES];

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        for (int s = 0; s < STAGES; s++) r_stage[s] <= '1;
      end else begin
        r_stage[0] <= i_d;
        for (int s = 1; s < STAGES; s++) r_stage[s] <= r_stage[s-1];
      end
    end

    assign o_q = r_stage[STAGES-1];
  end

endmodule

// File: rtl/m_sr_bank.sv
// Bank of WIDTH independent synchronous set/reset flags with active-low requests,
// optional input synchronisation, level/edge triggering and selectable conflict handling.
module m_sr_bank
  import sr_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MODE        = 0,
  parameter int unsigned EDGE        = 0
) (
  input  logic             MasterClock,
  input  logic             Reset,
  input  logic             Enable,
  input  logic [WIDTH-1:0] SL,
  input  logic [WIDTH-1:0] RL,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QL,
  output logic             Any,
  output logic [WIDTH-1:0] Changed
);

  if (WIDTH < 1 || WIDTH > SR_MAX_WIDTH) begin : g_bad_width
    $fatal(1, "m_sr_bank: WIDTH must be 1..32");
  end
  if (SYNC_STAGES > SR_MAX_SYNC) begin : g_bad_sync
    $fatal(1, "m_sr_bank: SYNC_STAGES must be 0..3");
  end
  if (MODE > SR_COMPAT) begin : g_bad_mode
    $fatal(1, "m_sr_bank: MODE must be 0..4");
  end
  if (EDGE > SR_EDGE) begin : g_bad_edge
    $fatal(1, "m_sr_bank: EDGE must be 0 or 1");
  end

  logic [WIDTH-1:0] w_s_sync, w_r_sync;
  logic [WIDTH-1:0] w_set_req, w_rst_req;
  logic [WIDTH-1:0] r_q, r_force, r_changed;
  logic             r_any;
  wire  [WIDTH-1:0] w_q_next, w_force_next;

  m_sr_sync #(.WIDTH(WIDTH), .STAGES(SYNC_STAGES)) u_sync_set (
    .i_clk (MasterClock),
    .i_rst (Reset),
    .i_d   (SL),
    .o_q   (w_s_sync)
  );

  m_sr_sync #(.WIDTH(WIDTH), .STAGES(SYNC_STAGES)) u_sync_rst (
    .i_clk (MasterClock),
    .i_rst (Reset),
    .i_d   (RL),
    .o_q   (w_r_sync)
  );

  if (EDGE == SR_EDGE) begin : g_edge
    // History runs regardless of Enable, so edges seen while disabled are consumed.
    logic [WIDTH-1:0] r_prev_s, r_prev_r;

    always_ff @(posedge MasterClock) begin
      if (Reset) begin
        r_prev_s <= '1;
        r_prev_r <= '1;
      end else begin
        r_prev_s <= w_s_sync;
        r_prev_r <= w_r_sync;
      end
    end

    assign w_set_req = r_prev_s & ~w_s_sync;
    assign w_rst_req = r_prev_r & ~w_r_sync;
  end else begin : g_level
    assign w_set_req = ~w_s_sync;
    assign w_rst_req = ~w_r_sync;
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    logic w_q_d, w_force_d;

    always_comb begin
      w_q_d     = r_q[i];
      w_force_d = 1'b0;
      case ({w_set_req[i], w_rst_req[i]})
        2'b10:   w_q_d = 1'b1;
        2'b01:   w_q_d = 1'b0;
        2'b11: begin
          case (MODE)
            SR_SET_WINS: w_q_d = 1'b1;
            SR_RST_WINS: w_q_d = 1'b0;
            SR_TOGGLE:   w_q_d = ~r_q[i];
            SR_COMPAT: begin
              w_q_d     = 1'b1;
              w_force_d = 1'b1;
            end
            default:     w_q_d = r_q[i];
          endcase
        end
        // Releasing a forced channel leaves Q=1, which yields QL=0 once force drops.
        default: w_q_d = r_q[i];
      endcase
    end

    assign w_q_next[i]     = w_q_d;
    assign w_force_next[i] = w_force_d;
  end

  always_ff @(posedge MasterClock) begin
    if (Reset) begin
      r_q       <= '0;
      r_force   <= '0;
      r_changed <= '0;
      r_any     <= 1'b0;
    end else if (Enable) begin
      r_q       <= w_q_next;
      r_force   <= w_force_next;
      r_changed <= w_q_next ^ r_q;
      r_any     <= |w_q_next;
    end else begin
      r_changed <= '0;
    end
  end

  assign Q       = r_q;
  assign QL      = ~r_q | r_force;
  assign Any     = r_any;
  assign Changed = r_changed;

endmodule

// File: tb/tb_m_sr_bank.sv
// Scoreboard bench for m_sr_bank: several parameterisations share random stimulus and are
// checked against a cycle-level reference model derived from the flag rules.
module tb_m_sr_bank;

  localparam int NDUT = 8;
  localparam int unsigned P_W [NDUT] = '{4, 8, 8, 32, 16, 32, 32, 1};
  localparam int unsigned P_S [NDUT] = '{2, 1, 0, 3, 2, 0, 0, 2};
  localparam int unsigned P_M [NDUT] = '{0, 1, 2, 3, 4, 4, 0, 3};
  localparam int unsigned P_E [NDUT] = '{0, 0, 1, 0, 0, 1, 0, 1};

  typedef struct packed {
    logic [NDUT-1:0][31:0] q;
    logic [NDUT-1:0][31:0] ql;
    logic [NDUT-1:0][31:0] chg;
    logic [NDUT-1:0]       any;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        en;
  logic [31:0] sl, rl;

  logic [31:0] d_q   [NDUT];
  logic [31:0] d_ql  [NDUT];
  logic [31:0] d_chg [NDUT];
  logic        d_any [NDUT];

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_push   = 0;
  int   n_pop    = 0;
  int   cyc      = 0;

  // Reference model state
  logic [31:0] h_sl[$], h_rl[$];
  bit          h_rst[$];
  logic [31:0] m_q [NDUT], m_ql [NDUT], m_chg [NDUT], m_ps [NDUT], m_pr [NDUT];
  bit          m_any [NDUT];

  for (genvar k = 0; k < NDUT; k++) begin : g_dut
    localparam int unsigned W = P_W[k];
    logic [W-1:0] q_l, ql_l, chg_l;

    m_sr_bank #(
      .WIDTH       (W),
      .SYNC_STAGES (P_S[k]),
      .MODE        (P_M[k]),
      .EDGE        (P_E[k])
    ) u_dut (
      .MasterClock (clk),
      .Reset       (rst),
      .Enable      (en),
      .SL          (sl[W-1:0]),
      .RL          (rl[W-1:0]),
      .Q           (q_l),
      .QL          (ql_l),
      .Any         (d_any[k]),
      .Changed     (chg_l)
    );

    assign d_q[k]   = 32'(q_l);
    assign d_ql[k]  = 32'(ql_l);
    assign d_chg[k] = 32'(chg_l);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int k, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL dut%0d %s cycle=%0d got=%h expected=%h", k, name, cyc, got, exp);
    end
  endtask

  // Advance the model by one rising edge with the given inputs, then queue the expectation.
  task automatic model_step(input bit r, input bit e, input logic [31:0] a_sl,
                            input logic [31:0] a_rl);
    int          n, idx;
    bit          ok;
    logic [31:0] mask, s, rr, old_q;
    bit          set_b, rst_b;
    exp_t        ex;
    h_sl.push_back(a_sl);
    h_rl.push_back(a_rl);
    h_rst.push_back(r);
    n = h_sl.size() - 1;
    for (int k = 0; k < NDUT; k++) begin
      mask = (P_W[k] == 32) ? 32'hFFFF_FFFF : ((32'd1 << P_W[k]) - 32'd1);
      if (r) begin
        m_q[k] = '0; m_ql[k] = mask; m_chg[k] = '0; m_any[k] = 1'b0;
        m_ps[k] = '1; m_pr[k] = '1;
      end else begin
        // Synchronised view: input from SYNC_STAGES edges ago, unless a reset cleared it.
        idx = n - int'(P_S[k]);
        ok  = (idx >= 0);
        for (int j = (idx < 0 ? 0 : idx); j < n; j++) if (h_rst[j]) ok = 1'b0;
        s  = ok ? h_sl[idx] : '1;
        rr = ok ? h_rl[idx] : '1;
        old_q = m_q[k];
        if (e) begin
          for (int b = 0; b < int'(P_W[k]); b++) begin
            set_b = (P_E[k] == 1) ? (m_ps[k][b] && !s[b])  : !s[b];
            rst_b = (P_E[k] == 1) ? (m_pr[k][b] && !rr[b]) : !rr[b];
            if (set_b && !rst_b) begin
              m_q[k][b] = 1'b1; m_ql[k][b] = 1'b0;
            end else if (!set_b && rst_b) begin
              m_q[k][b] = 1'b0; m_ql[k][b] = 1'b1;
            end else if (!set_b && !rst_b) begin
              if (m_q[k][b] && m_ql[k][b]) m_ql[k][b] = 1'b0;
            end else begin
              case (P_M[k])
                0: begin m_q[k][b] = 1'b1; m_ql[k][b] = 1'b0; end
                1: begin m_q[k][b] = 1'b0; m_ql[k][b] = 1'b1; end
                3: begin m_q[k][b] = !old_q[b]; m_ql[k][b] = old_q[b]; end
                4: begin m_q[k][b] = 1'b1; m_ql[k][b] = 1'b1; end
                default: ;
              endcase
            end
          end
          m_chg[k] = m_q[k] ^ old_q;
          m_any[k] = (m_q[k] != 0);
        end else begin
          m_chg[k] = '0;
        end
        m_ps[k] = s;
        m_pr[k] = rr;
      end
      ex.q[k]   = m_q[k];
      ex.ql[k]  = m_ql[k];
      ex.chg[k] = m_chg[k];
      ex.any[k] = m_any[k];
    end
    sb.push_back(ex);
    n_push++;
  endtask

  task automatic drive(input bit r, input bit e, input logic [31:0] a_sl,
                       input logic [31:0] a_rl, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      rst = r; en = e; sl = a_sl; rl = a_rl;
      model_step(r, e, a_sl, a_rl);
    end
  endtask

  // Monitor: every cycle the DUTs present outputs; compare against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        n_pop++;
        for (int k = 0; k < NDUT; k++) begin
          check("Q", k, d_q[k], e.q[k]);
          check("QL", k, d_ql[k], e.ql[k]);
          check("Changed", k, d_chg[k], e.chg[k]);
          check("Any", k, 32'(d_any[k]), 32'(e.any[k]));
        end
      end
    end
  end

  initial begin
    int          len;
    bit          r_b, e_b;
    logic [31:0] a_sl, a_rl;
    rst = 1'b1; en = 1'b1; sl = '1; rl = '1;
    drive(1'b1, 1'b1, '1, '1, 3);
    // Basic set then clear of channel 0
    drive(1'b0, 1'b1, 32'hFFFF_FFFE, '1, 1);
    drive(1'b0, 1'b1, '1, '1, 4);
    drive(1'b0, 1'b1, '1, 32'hFFFF_FFFE, 1);
    drive(1'b0, 1'b1, '1, '1, 5);
    // Both requests held, then released together
    drive(1'b0, 1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 7);
    drive(1'b0, 1'b1, '1, '1, 5);
    // Long low level on channel 2, then a reset pulse while disabled
    drive(1'b0, 1'b1, 32'hFFFF_FFFB, '1, 10);
    drive(1'b0, 1'b1, '1, '1, 4);
    drive(1'b0, 1'b0, '1, 32'hFFFF_FFFB, 1);
    drive(1'b0, 1'b0, '1, '1, 5);
    drive(1'b0, 1'b1, '1, '1, 3);
    // Enable gating with a level set request on channel 3
    drive(1'b0, 1'b0, 32'hFFFF_FFF7, '1, 5);
    drive(1'b0, 1'b1, 32'hFFFF_FFF7, '1, 2);
    drive(1'b0, 1'b1, '1, '1, 4);
    // Reset lands while a set request is still in the synchroniser
    drive(1'b0, 1'b1, '1, 32'h0000_0000, 5);
    drive(1'b0, 1'b1, '1, '1, 4);
    drive(1'b0, 1'b1, 32'h0000_0000, '1, 1);
    drive(1'b1, 1'b1, 32'h0000_0000, '1, 1);
    drive(1'b0, 1'b1, '1, '1, 6);
    // Randomised phases: sparse or dense requests held for a few cycles
    while (n_push < 10000) begin
      len  = $urandom_range(1, 6);
      a_sl = ($urandom_range(0, 1) == 1) ? ($urandom | $urandom) : $urandom;
      a_rl = ($urandom_range(0, 1) == 1) ? ($urandom | $urandom) : $urandom;
      for (int c = 0; c < len; c++) begin
        r_b = ($urandom_range(0, 199) == 0);
        e_b = ($urandom_range(0, 9) != 0);
        drive(r_b, e_b, a_sl, a_rl, 1);
      end
    end
    drive(1'b0, 1'b1, '1, '1, 2);
    repeat (3) @(posedge clk);
    #2;
    check("scoreboard_drained", 0, 32'(sb.size()), 32'd0);
    check("pops_vs_pushes", 0, 32'(n_pop), 32'(n_push));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
